// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and types for the VGA raster generator.
//   - 640x480@60 default timing (pixels / lines)
//   - axis_total(): sums the four segment lengths of one axis
//   - phase_e: the four raster phases of one axis
//   Counter width is 10 bits, so each axis total must be <= 1024.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int CNT_W     = 10;          // pix_x / pix_y width
    localparam int LEN_W     = CNT_W + 1;   // holds a total of up to 1024
    localparam int MAX_TOTAL = 1 << CNT_W;

    // Gray-coded so every legal transition flips one bit; the sync and
    // active decodes of these flops therefore cannot glitch.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'b00,
        PH_FRONT  = 2'b01,
        PH_SYNC   = 2'b11,
        PH_BACK   = 2'b10
    } phase_e;

    function automatic int axis_total(input int vis, input int front,
                                      input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/mod_vga_axis_counter.sv
// ---------------------------------------------------------------------------
// mod_vga_axis_counter
//   One raster axis: a position counter plus the phase FSM that tracks
//   ACTIVE -> FRONT -> SYNC -> BACK. Used once for columns, once for lines.
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     adv_i             advance the position by one this clock
//     vis_len_i ..      lengths of the visible, front porch, sync and
//     back_len_i        back porch segments (each >= 1)
//     count_o           current position, 0..total-1
//     phase_o           current phase (FSM state, also useful for debug)
//     wrap_o            high on the advancing clock that returns count to 0
// ---------------------------------------------------------------------------
module mod_vga_axis_counter
    import vga_timing_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    input  logic [LEN_W-1:0] vis_len_i,
    input  logic [LEN_W-1:0] front_len_i,
    input  logic [LEN_W-1:0] sync_len_i,
    input  logic [LEN_W-1:0] back_len_i,
    output logic [CNT_W-1:0] count_o,
    output phase_e           phase_o,
    output logic             wrap_o
);

    logic [LEN_W-1:0] sync_start;
    logic [LEN_W-1:0] back_start;
    logic [LEN_W-1:0] last_idx;
    logic [LEN_W-1:0] count_ext;
    logic [LEN_W-1:0] count_inc;
    logic             at_last;

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;

    assign sync_start = vis_len_i + front_len_i;
    assign back_start = sync_start + sync_len_i;
    assign last_idx   = back_start + back_len_i - LEN_W'(1);

    assign count_ext  = {1'b0, count_q};
    assign count_inc  = count_ext + LEN_W'(1);
    assign at_last    = (count_ext == last_idx);
    assign wrap_o     = adv_i & at_last;

    // Phase changes are decided on the value the counter is about to take,
    // so the phase flop and the counter flop move on the same edge.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (adv_i) begin
            if (at_last) begin
                count_d = '0;
                phase_d = PH_ACTIVE;
            end else begin
                count_d = count_inc[CNT_W-1:0];
                case (phase_q)
                    PH_ACTIVE: if (count_inc == vis_len_i)  phase_d = PH_FRONT;
                    PH_FRONT:  if (count_inc == sync_start) phase_d = PH_SYNC;
                    PH_SYNC:   if (count_inc == back_start) phase_d = PH_BACK;
                    default:   phase_d = phase_q;  // BACK leaves only on wrap
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count_o = count_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/mod_vga_timing.sv
// ---------------------------------------------------------------------------
// mod_vga_timing
//   640x480@60 VGA raster generator (timing is parameterised).
//   Ports:
//     clk          system clock
//     reset        asynchronous active-high reset
//     pix_tick     one-clk pulse per pixel period (every CLK_DIV clks)
//     pix_x/pix_y  current column / line
//     active       visible region
//     hsync/vsync  sync pulses, asserted low when SYNC_ACTIVE_LOW != 0
//     frame_start  pulse on the pix_tick that wraps the raster to (0,0)
//   Build option VGA_PIPE_ALIGN_EN: when defined, active/hsync/vsync are
//   delayed by one pixel to line up with one-pixel-latency overlays;
//   pix_x/pix_y are never delayed.
// ---------------------------------------------------------------------------
module mod_vga_timing
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV         = DEF_CLK_DIV,
    parameter int H_VISIBLE       = DEF_H_VISIBLE,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_VISIBLE       = DEF_V_VISIBLE,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_tick,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int DIV_W   = 3;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic SYNC_ON = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $error("mod_vga_timing: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_div_check
        $error("mod_vga_timing: CLK_DIV must be in 1..8");
    end

    // ---------------- pixel-rate divider ----------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    // Stays low until the first pixel edge so nothing looks "visible"
    // between reset release and the first counter advance.
    logic             vid_en_q, vid_en_d;

    always_comb begin
        div_d    = div_q + DIV_W'(1);
        tick_d   = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
        end
        vid_en_d = vid_en_q | tick_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            vid_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            vid_en_q <= vid_en_d;
        end
    end

    // ---------------- axis counters ----------------
    phase_e h_phase, v_phase;
    logic   h_wrap, v_wrap;

    mod_vga_axis_counter u_h_axis (
        .clk_i       (clk),
        .rst_i       (reset),
        .adv_i       (tick_q),
        .vis_len_i   (LEN_W'(H_VISIBLE)),
        .front_len_i (LEN_W'(H_FRONT)),
        .sync_len_i  (LEN_W'(H_SYNC)),
        .back_len_i  (LEN_W'(H_BACK)),
        .count_o     (pix_x),
        .phase_o     (h_phase),
        .wrap_o      (h_wrap)
    );

    mod_vga_axis_counter u_v_axis (
        .clk_i       (clk),
        .rst_i       (reset),
        .adv_i       (h_wrap),
        .vis_len_i   (LEN_W'(V_VISIBLE)),
        .front_len_i (LEN_W'(V_FRONT)),
        .sync_len_i  (LEN_W'(V_SYNC)),
        .back_len_i  (LEN_W'(V_BACK)),
        .count_o     (pix_y),
        .phase_o     (v_phase),
        .wrap_o      (v_wrap)
    );

    // ---------------- strobes ----------------
    // Decoded straight from the phase flops, so they switch on the same
    // edge as pix_x/pix_y; the Gray phase code keeps them glitch-free.
    logic active_raw, hsync_raw, vsync_raw;

    assign active_raw = vid_en_q & (h_phase == PH_ACTIVE) & (v_phase == PH_ACTIVE);
    assign hsync_raw  = (h_phase == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
    assign vsync_raw  = (v_phase == PH_SYNC) ? SYNC_ON : ~SYNC_ON;

`ifdef VGA_PIPE_ALIGN_EN
    logic active_dly_q, active_dly_d;
    logic hsync_dly_q,  hsync_dly_d;
    logic vsync_dly_q,  vsync_dly_d;

    always_comb begin
        active_dly_d = active_dly_q;
        hsync_dly_d  = hsync_dly_q;
        vsync_dly_d  = vsync_dly_q;
        if (tick_q) begin
            active_dly_d = active_raw;
            hsync_dly_d  = hsync_raw;
            vsync_dly_d  = vsync_raw;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_dly_q <= 1'b0;
            hsync_dly_q  <= ~SYNC_ON;
            vsync_dly_q  <= ~SYNC_ON;
        end else begin
            active_dly_q <= active_dly_d;
            hsync_dly_q  <= hsync_dly_d;
            vsync_dly_q  <= vsync_dly_d;
        end
    end

    assign active = active_dly_q;
    assign hsync  = hsync_dly_q;
    assign vsync  = vsync_dly_q;
`else
    assign active = active_raw;
    assign hsync  = hsync_raw;
    assign vsync  = vsync_raw;
`endif

    assign pix_tick    = tick_q;
    // v_wrap already implies h_wrap and tick_q.
    assign frame_start = tick_q & v_wrap;

endmodule

// File: doc/mod_vga_timing.md
Name: mod_vga_timing

Overview:
Generates the 640x480@60 VGA raster: pixel-rate tick, pix_x/pix_y position counters, hsync/vsync and active-video strobes. Sits directly upstream of mod_hex_display and any other overlay module, which consume pix_x/pix_y. Also drives the board sync pins. Provides a frame_start pulse so overlays can latch their data once per frame.

Parameters:
CLK_DIV, 2, system clocks per pixel (1..8); 2 gives a 25 MHz pixel rate from a 50 MHz clock.
H_VISIBLE, 640, visible pixels per line.
H_FRONT, 16, horizontal front porch, in pixels.
H_SYNC, 96, horizontal sync width, in pixels.
H_BACK, 48, horizontal back porch, in pixels.
V_VISIBLE, 480, visible lines.
V_FRONT, 10, vertical front porch, in lines.
V_SYNC, 2, vertical sync width, in lines.
V_BACK, 33, vertical back porch, in lines.
SYNC_ACTIVE_LOW, 1, 1 means hsync/vsync are driven low during the sync pulse.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  asynchronous, active-high reset.
pix_tick  out  1  one-clk pulse per pixel period.
pix_x  out  10  current column, 0..H_TOTAL-1.
pix_y  out  10  current line, 0..V_TOTAL-1.
active  out  1  high when pix_x < H_VISIBLE and pix_y < V_VISIBLE.
hsync  out  1  horizontal sync, polarity set by SYNC_ACTIVE_LOW.
vsync  out  1  vertical sync, polarity set by SYNC_ACTIVE_LOW.
frame_start  out  1  one-clk pulse coincident with the pix_tick that wraps the raster to (0,0).

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters = 800; V_TOTAL = sum of the four V parameters = 525. Both totals must be <= 1024; this is checked at elaboration.
- Reset is asynchronous and active-high. While reset is asserted:
  - divider, pix_x and pix_y are 0;
  - pix_tick, active and frame_start are 0;
  - hsync and vsync are at their inactive level (1 when SYNC_ACTIVE_LOW=1);
  - both phase FSMs are in *_ACTIVE.
- Divider: counts 0..CLK_DIV-1. pix_tick is registered high on the clk after the count reaches CLK_DIV-1. The first pix_tick after reset release occurs CLK_DIV clks later. With CLK_DIV=1, pix_tick is constantly 1 after the first clk.
- On each pix_tick edge, pix_x advances. At H_TOTAL-1 it wraps to 0 and pix_y advances. pix_y wraps from V_TOTAL-1 to 0.
- Counters and all outputs hold between ticks.
- Horizontal phase FSM, transitions on pix_tick:
  - H_ACTIVE to H_FRONT when pix_x becomes H_VISIBLE;
  - H_FRONT to H_SYNC at H_VISIBLE+H_FRONT;
  - H_SYNC to H_BACK at H_VISIBLE+H_FRONT+H_SYNC;
  - H_BACK to H_ACTIVE at the wrap to 0.
- Vertical FSM: same four states, on line advance, against the V thresholds.
- hsync is asserted only in H_SYNC (pix_x 656..751); vsync only in V_SYNC (pix_y 490..491).
- Registered outputs change on the same clk edge as the counters, so pix_x/pix_y, active, hsync and vsync are always mutually consistent.
- frame_start equals pix_tick AND (pix_x, pix_y wrap to 0,0). It is never asserted on the first tick after reset.
- Reset asserted mid-frame: all state clears immediately (asynchronous). After release the raster restarts from (0,0) with no partial-sync glitch.

Optional Feature:
VGA_PIPE_ALIGN_EN
- Defined: active, hsync and vsync are delayed by one extra pix_tick, matching the one-pixel registered latency of overlay modules. pix_x and pix_y are not delayed. The delay registers reset to the inactive values.
- Undefined: no delay; the outputs behave as described above.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 default constants;
  - the H_TOTAL/V_TOTAL derivation;
  - the phase enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}.
- Sub-module mod_vga_axis_counter is generic counter + phase FSM (inputs: advance enable and the four lengths; outputs: count, phase, wrap). It is instantiated twice: H, advanced by pix_tick; V, advanced by H wrap.

Test Plan:
- Reset release, CLK_DIV=2 -> first pix_tick at clk 2 after release; pix_x=1 after that tick, pix_y=0; active=1; hsync=vsync=1.
- Run 656 ticks -> hsync falls as pix_x becomes 656; rises as pix_x becomes 752; active=0 from pix_x=640.
- Run a full line (800 ticks) -> pix_x wraps to 0 and pix_y becomes 1 on the same edge.
- Run a full frame (420000 ticks) -> exactly one frame_start pulse, 1 clk wide, at the wrap to (0,0); vsync low for exactly 1600 ticks (lines 490..491).
- Assert reset mid-line at pix_x=300, pix_y=200 -> all outputs are at reset values within the same cycle; after release the raster restarts from (0,0).
- VGA_PIPE_ALIGN_EN defined -> hsync falls one pix_tick after pix_x reaches 656; active falls one tick after pix_x=640.
